// File: rtl/cfr_ipif_pkg.sv
// Shared types and helpers for the CFR IPIF address demultiplexer.
package cfr_ipif_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} ipif_state_t;

  // Width of the branch-select field; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfr_ipif_demux_ch.sv
// One IPIF channel of the demux: select latch, per-transaction FSM,
// ack timeout and error response. The read and write channels are two
// instances; HAS_DATA_OUT enables the per-branch write-data registers.
module cfr_ipif_demux_ch
  import cfr_ipif_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BRANCH = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit HAS_DATA_OUT = 1'b1,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = '0,
  localparam int SW = sel_width(NUM_BRANCH),
  localparam int BW = ADDR_WIDTH - SW
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ADDR_WIDTH-1:0]                addr_i,
  input  logic                                 req_i,
  input  logic [DATA_WIDTH-1:0]                data_i,
  output logic                                 ack_o,
  output logic                                 err_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic                                 timeout_o,
  output logic [NUM_BRANCH-1:0]                br_req_o,
  output logic [NUM_BRANCH-1:0][BW-1:0]        br_addr_o,
  output logic [NUM_BRANCH-1:0][DATA_WIDTH-1:0] br_data_o,
  input  logic [NUM_BRANCH-1:0]                br_ack_i,
  input  logic [NUM_BRANCH-1:0][DATA_WIDTH-1:0] br_rdata_i
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; the WAIT cycle that sees
  // that value is the last one before the error ack.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  ipif_state_t                       state_q;
  logic [SW-1:0]                     sel_q;
  logic [TW-1:0]                     cnt_q;
  logic                              ack_q;
  logic                              err_q;
  logic [NUM_BRANCH-1:0]             br_req_q;
  logic [NUM_BRANCH-1:0][BW-1:0]     br_addr_q;
  logic [DATA_WIDTH-1:0]             rdata_q;

  logic [SW-1:0]                     sel_in;
  logic [BW-1:0]                     loc_in;
  logic                              sel_mapped;
  logic                              start;
  logic                              ack_sel;
  logic [DATA_WIDTH-1:0]             rdata_sel;
  logic                              resp_ok;
  logic                              resp_err;
  logic                              timeout_hit;

  assign sel_in     = addr_i[ADDR_WIDTH-1 -: SW];
  assign loc_in     = addr_i[BW-1:0];
  assign sel_mapped = (int'(sel_in) < NUM_BRANCH);
  assign start      = (state_q == IDLE) && req_i;

  // Route the latched branch's ack and read data back; the live address is never used here.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int b = 0; b < NUM_BRANCH; b++) begin
      if (sel_q == SW'(b)) begin
        ack_sel   = br_ack_i[b];
        rdata_sel = br_rdata_i[b];
      end
    end
  end

  assign resp_ok     = ((state_q == ISSUE) || (state_q == WAIT)) && ack_sel;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state_q == WAIT) && !ack_sel && (cnt_q == TO_LAST);
  assign resp_err    = (start && !sel_mapped) || timeout_hit;

  // Transaction FSM with registered branch request/address and upstream ack/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      br_req_q  <= '0;
      br_addr_q <= '0;
    end else begin
      ack_q    <= resp_ok || resp_err;
      err_q    <= resp_err;
      br_req_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            sel_q <= sel_in;
            cnt_q <= '0;
            if (sel_mapped) begin
              state_q <= ISSUE;
              for (int b = 0; b < NUM_BRANCH; b++) begin
                if (sel_in == SW'(b)) begin
                  br_req_q[b]  <= 1'b1;
                  br_addr_q[b] <= loc_in;
                end
              end
            end else begin
              state_q <= RESP;
            end
          end
        end
        ISSUE: state_q <= ack_sel ? RESP : WAIT;
        WAIT: begin
          if (ack_sel || timeout_hit) begin
            state_q <= RESP;
          end else if (TIMEOUT_CYCLES > 0) begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is captured once per completion and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (resp_ok) begin
      rdata_q <= rdata_sel;
    end else if (resp_err) begin
      rdata_q <= ERR_DATA;
    end
  end

  generate
    if (HAS_DATA_OUT) begin : g_wdata
      logic [NUM_BRANCH-1:0][DATA_WIDTH-1:0] br_data_q;

      // Write data lands only in the selected branch's register; the others hold.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          br_data_q <= '0;
        end else if (start && sel_mapped) begin
          for (int b = 0; b < NUM_BRANCH; b++) begin
            if (sel_in == SW'(b)) begin
              br_data_q[b] <= data_i;
            end
          end
        end
      end

      assign br_data_o = br_data_q;
    end else begin : g_no_wdata
      logic unused_data;
      assign unused_data = ^data_i;
      assign br_data_o   = '0;
    end
  endgenerate

  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign timeout_o = timeout_hit;
  assign br_req_o  = br_req_q;
  assign br_addr_o = br_addr_q;

endmodule

// File: rtl/cfr_ipif_demux.sv
// IPIF address demultiplexer: fans one upstream IPIF port out to
// NUM_BRANCH register branches (CFR cores, pulse/threshold RAMs).
// Read and write channels run independently; this level also keeps a
// saturating count of ack timeouts from both channels.
module cfr_ipif_demux
  import cfr_ipif_pkg::*;
#(
  parameter int IPIF_ADDR_WIDTH = 15,
  parameter int IPIF_DATA_WIDTH = 32,
  parameter int NUM_BRANCH = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter logic [IPIF_DATA_WIDTH-1:0] UNMAPPED_RD_DATA = 32'hDEAD_BEEF,
  localparam int SW = sel_width(NUM_BRANCH),
  localparam int BW = IPIF_ADDR_WIDTH - SW
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [IPIF_ADDR_WIDTH-1:0]                wr_addr_i,
  input  logic                                      wr_req_i,
  input  logic [IPIF_DATA_WIDTH-1:0]                wr_data_i,
  output logic                                      wr_ack_o,
  output logic                                      wr_err_o,
  input  logic [IPIF_ADDR_WIDTH-1:0]                rd_addr_i,
  input  logic                                      rd_req_i,
  output logic [IPIF_DATA_WIDTH-1:0]                rd_data_o,
  output logic                                      rd_ack_o,
  output logic                                      rd_err_o,
  output logic [NUM_BRANCH-1:0][BW-1:0]             ipif_wr_addr_o,
  output logic [NUM_BRANCH-1:0]                     ipif_wr_req_o,
  output logic [NUM_BRANCH-1:0][IPIF_DATA_WIDTH-1:0] ipif_wr_data_o,
  input  logic [NUM_BRANCH-1:0]                     ipif_wr_ack_i,
  output logic [NUM_BRANCH-1:0][BW-1:0]             ipif_rd_addr_o,
  output logic [NUM_BRANCH-1:0]                     ipif_rd_req_o,
  input  logic [NUM_BRANCH-1:0][IPIF_DATA_WIDTH-1:0] ipif_rd_data_i,
  input  logic [NUM_BRANCH-1:0]                     ipif_rd_ack_i,
  output logic [15:0]                               timeout_count_o
);

  logic                                       wr_timeout;
  logic                                       rd_timeout;
  logic [IPIF_DATA_WIDTH-1:0]                 unused_wr_rdata;
  logic [NUM_BRANCH-1:0][IPIF_DATA_WIDTH-1:0] unused_rd_bdata;
  logic [15:0]                                timeout_count_q;
  logic [16:0]                                to_sum;

  cfr_ipif_demux_ch #(
    .ADDR_WIDTH     (IPIF_ADDR_WIDTH),
    .DATA_WIDTH     (IPIF_DATA_WIDTH),
    .NUM_BRANCH     (NUM_BRANCH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .HAS_DATA_OUT   (1'b1),
    .ERR_DATA       (UNMAPPED_RD_DATA)
  ) u_wr_ch (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (wr_addr_i),
    .req_i      (wr_req_i),
    .data_i     (wr_data_i),
    .ack_o      (wr_ack_o),
    .err_o      (wr_err_o),
    .rdata_o    (unused_wr_rdata),
    .timeout_o  (wr_timeout),
    .br_req_o   (ipif_wr_req_o),
    .br_addr_o  (ipif_wr_addr_o),
    .br_data_o  (ipif_wr_data_o),
    .br_ack_i   (ipif_wr_ack_i),
    .br_rdata_i ('0)
  );

  cfr_ipif_demux_ch #(
    .ADDR_WIDTH     (IPIF_ADDR_WIDTH),
    .DATA_WIDTH     (IPIF_DATA_WIDTH),
    .NUM_BRANCH     (NUM_BRANCH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .HAS_DATA_OUT   (1'b0),
    .ERR_DATA       (UNMAPPED_RD_DATA)
  ) u_rd_ch (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (rd_addr_i),
    .req_i      (rd_req_i),
    .data_i     ('0),
    .ack_o      (rd_ack_o),
    .err_o      (rd_err_o),
    .rdata_o    (rd_data_o),
    .timeout_o  (rd_timeout),
    .br_req_o   (ipif_rd_req_o),
    .br_addr_o  (ipif_rd_addr_o),
    .br_data_o  (unused_rd_bdata),
    .br_ack_i   (ipif_rd_ack_i),
    .br_rdata_i (ipif_rd_data_i)
  );

  // Both channels can time out in the same cycle, so the sum can step by two.
  assign to_sum = {1'b0, timeout_count_q} + {16'd0, wr_timeout} + {16'd0, rd_timeout};

  // Saturating timeout accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_count_q <= '0;
    end else begin
      timeout_count_q <= to_sum[16] ? 16'hFFFF : to_sum[15:0];
    end
  end

  assign timeout_count_o = timeout_count_q;

endmodule

// File: tb/tb_cfr_ipif_demux.sv
// Directed bench for cfr_ipif_demux: a vector table of single accesses
// plus hand-written sequences for concurrency, reset and saturation.
module tb_cfr_ipif_demux;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int NB = 20;
  localparam int TO = 8;
  localparam int BW = 10;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [AW-1:0]          wr_addr_i = '0;
  logic                   wr_req_i = 1'b0;
  logic [DW-1:0]          wr_data_i = '0;
  logic                   wr_ack_o;
  logic                   wr_err_o;
  logic [AW-1:0]          rd_addr_i = '0;
  logic                   rd_req_i = 1'b0;
  logic [DW-1:0]          rd_data_o;
  logic                   rd_ack_o;
  logic                   rd_err_o;
  logic [NB-1:0][BW-1:0]  ipif_wr_addr_o;
  logic [NB-1:0]          ipif_wr_req_o;
  logic [NB-1:0][DW-1:0]  ipif_wr_data_o;
  logic [NB-1:0]          ipif_wr_ack_i = '0;
  logic [NB-1:0][BW-1:0]  ipif_rd_addr_o;
  logic [NB-1:0]          ipif_rd_req_o;
  logic [NB-1:0][DW-1:0]  ipif_rd_data_i;
  logic [NB-1:0]          ipif_rd_ack_i = '0;
  logic [15:0]            timeout_count_o;

  cfr_ipif_demux #(
    .IPIF_ADDR_WIDTH  (AW),
    .IPIF_DATA_WIDTH  (DW),
    .NUM_BRANCH       (NB),
    .TIMEOUT_CYCLES   (TO),
    .UNMAPPED_RD_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_addr_i       (wr_addr_i),
    .wr_req_i        (wr_req_i),
    .wr_data_i       (wr_data_i),
    .wr_ack_o        (wr_ack_o),
    .wr_err_o        (wr_err_o),
    .rd_addr_i       (rd_addr_i),
    .rd_req_i        (rd_req_i),
    .rd_data_o       (rd_data_o),
    .rd_ack_o        (rd_ack_o),
    .rd_err_o        (rd_err_o),
    .ipif_wr_addr_o  (ipif_wr_addr_o),
    .ipif_wr_req_o   (ipif_wr_req_o),
    .ipif_wr_data_o  (ipif_wr_data_o),
    .ipif_wr_ack_i   (ipif_wr_ack_i),
    .ipif_rd_addr_o  (ipif_rd_addr_o),
    .ipif_rd_req_o   (ipif_rd_req_o),
    .ipif_rd_data_i  (ipif_rd_data_i),
    .ipif_rd_ack_i   (ipif_rd_ack_i),
    .timeout_count_o (timeout_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [14:0] addr;
    logic [31:0] wdata;
    int          ack_dly;   // cycles after branch req; -1 = never acks
    int          exp_lat;   // upstream ack cycle relative to req cycle
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_reqs;
    logic [15:0] exp_to;
  } vec_t;

  int   n_pass = 0;
  int   n_chk  = 0;
  int   lat_h;
  vec_t vt[11];
  vec_t vh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input bit w, input logic [4:0] sel, input logic [9:0] loc,
                              input logic [31:0] wd, input int dly, input int lat,
                              input bit err, input logic [31:0] rdat, input int reqs,
                              input logic [15:0] to);
    vec_t v;
    v.is_wr = w; v.addr = {sel, loc}; v.wdata = wd; v.ack_dly = dly; v.exp_lat = lat;
    v.exp_err = err; v.exp_rdata = rdat; v.exp_reqs = reqs; v.exp_to = to;
    return v;
  endfunction

  // Issue one access at the current cycle and follow it to its upstream ack.
  task automatic do_access(input vec_t v, input string tag);
    int br;
    int req_cyc;
    int nreq;
    int lat;
    br = int'(v.addr[14:10]);
    if (v.is_wr) begin
      wr_addr_i = v.addr; wr_data_i = v.wdata; wr_req_i = 1'b1;
    end else begin
      rd_addr_i = v.addr; rd_req_i = 1'b1;
    end
    step();
    wr_req_i = 1'b0;
    rd_req_i = 1'b0;
    req_cyc = -1; nreq = 0; lat = -1;
    for (int c = 1; c <= 40; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (v.is_wr ? ipif_wr_req_o[b] : ipif_rd_req_o[b]) begin
          nreq++;
          req_cyc = c;
          check({tag, " branch"}, b, br);
          check({tag, " local addr"}, v.is_wr ? ipif_wr_addr_o[b] : ipif_rd_addr_o[b], {22'd0, v.addr[9:0]});
          if (v.is_wr) check({tag, " branch wdata"}, ipif_wr_data_o[b], v.wdata);
        end
      end
      ipif_wr_ack_i = '0;
      ipif_rd_ack_i = '0;
      if (v.is_wr ? wr_ack_o : rd_ack_o) begin
        lat = c;
        check({tag, " err"}, v.is_wr ? wr_err_o : rd_err_o, v.exp_err);
        if (!v.is_wr) check({tag, " rdata"}, rd_data_o, v.exp_rdata);
        check({tag, " timeout_count"}, timeout_count_o, v.exp_to);
        step();
        break;
      end
      if (v.ack_dly >= 0 && req_cyc >= 0 && c == req_cyc + v.ack_dly) begin
        if (v.is_wr) ipif_wr_ack_i[br] = 1'b1;
        else         ipif_rd_ack_i[br] = 1'b1;
      end
      step();
    end
    ipif_wr_ack_i = '0;
    ipif_rd_ack_i = '0;
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " branch req count"}, nreq, v.exp_reqs);
    if (v.is_wr) check({tag, " ack one cycle"}, wr_ack_o, 1'b0);
    else         check({tag, " ack one cycle"}, rd_ack_o, 1'b0);
  endtask

  initial begin
    for (int b = 0; b < NB; b++) ipif_rd_data_i[b] = 32'hC0DE_0000 + b;

    //            wr    sel    loc      wdata         dly lat err rdata          reqs to
    vt[0]  = mk(1'b1, 5'd3,  10'h01A, 32'h1234_5678,  2,  4, 1'b0, 32'h0,         1, 16'd0);
    vt[1]  = mk(1'b0, 5'd25, 10'h000, 32'h0,         -1,  1, 1'b1, 32'hDEAD_BEEF, 0, 16'd0);
    vt[2]  = mk(1'b0, 5'd7,  10'h055, 32'h0,         -1, 10, 1'b1, 32'hDEAD_BEEF, 1, 16'd1);
    vt[3]  = mk(1'b0, 5'd19, 10'h3FF, 32'h0,          0,  2, 1'b0, 32'hC0DE_0013, 1, 16'd1);
    vt[4]  = mk(1'b1, 5'd20, 10'h000, 32'h5555_AAAA, -1,  1, 1'b1, 32'h0,         0, 16'd1);
    vt[5]  = mk(1'b1, 5'd0,  10'h2AA, 32'hA5A5_A5A5,  5,  7, 1'b0, 32'h0,         1, 16'd1);
    vt[6]  = mk(1'b1, 5'd12, 10'h001, 32'h0BAD_CAFE, -1, 10, 1'b1, 32'h0,         1, 16'd2);
    vt[7]  = mk(1'b0, 5'd10, 10'h123, 32'h0,          1,  3, 1'b0, 32'hC0DE_000A, 1, 16'd2);
    vt[8]  = mk(1'b0, 5'd31, 10'h3FF, 32'h0,         -1,  1, 1'b1, 32'hDEAD_BEEF, 0, 16'd2);
    vt[9]  = mk(1'b0, 5'd7,  10'h0AB, 32'h0,          7,  9, 1'b0, 32'hC0DE_0007, 1, 16'd2);
    vt[10] = mk(1'b0, 5'd7,  10'h0AC, 32'h0,          8, 10, 1'b0, 32'hC0DE_0007, 1, 16'd2);

    // Reset state
    step(); step();
    check("reset wr_ack", wr_ack_o, 1'b0);
    check("reset rd_ack", rd_ack_o, 1'b0);
    check("reset rd_data", rd_data_o, 32'h0);
    check("reset timeout_count", timeout_count_o, 16'h0);
    check("reset branch reqs", (ipif_wr_req_o == '0) && (ipif_rd_req_o == '0), 1'b1);
    check("reset branch addr/data", (ipif_wr_addr_o == '0) && (ipif_wr_data_o == '0) && (ipif_rd_addr_o == '0), 1'b1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) do_access(vt[i], $sformatf("vec%0d", i));

    check("rd_data hold across writes", rd_data_o, 32'hC0DE_0007);
    check("wr branch 3 data held", ipif_wr_data_o[3], 32'h1234_5678);
    check("wr branch 5 untouched", ipif_wr_data_o[5], 32'h0);

    // Late ack after a timeout is ignored
    do_access(mk(1'b0, 5'd7, 10'h066, 32'h0, -1, 10, 1'b1, 32'hDEAD_BEEF, 1, 16'd3), "late");
    step();
    ipif_rd_ack_i[7] = 1'b1;
    step();
    ipif_rd_ack_i = '0;
    check("late ack no rd_ack", rd_ack_o, 1'b0);
    step();
    check("late ack no rd_ack +1", rd_ack_o, 1'b0);
    check("late ack timeout_count", timeout_count_o, 16'd3);
    check("late ack rd_data held", rd_data_o, 32'hDEAD_BEEF);

    // Concurrent read (branch 5) and write (branch 9), live rd_addr changed, spurious ack on 6
    rd_addr_i = {5'd5, 10'h011}; rd_req_i = 1'b1;
    step();
    rd_req_i = 1'b0;
    rd_addr_i = {5'd6, 10'h022};
    wr_addr_i = {5'd9, 10'h033}; wr_data_i = 32'hFEED_F00D; wr_req_i = 1'b1;
    check("conc rd req vector", ipif_rd_req_o, 32'h0000_0020);
    check("conc rd addr", ipif_rd_addr_o[5], 32'h011);
    step();
    wr_req_i = 1'b0;
    check("conc wr req vector", ipif_wr_req_o, 32'h0000_0200);
    check("conc wr data", ipif_wr_data_o[9], 32'hFEED_F00D);
    check("conc rd req dropped", ipif_rd_req_o, 32'h0);
    ipif_rd_ack_i[6] = 1'b1;
    ipif_wr_ack_i[9] = 1'b1;
    step();
    ipif_rd_ack_i = '0;
    ipif_wr_ack_i = '0;
    check("conc spurious ack ignored", rd_ack_o, 1'b0);
    check("conc wr_ack", wr_ack_o, 1'b1);
    check("conc wr_err", wr_err_o, 1'b0);
    ipif_rd_ack_i[5] = 1'b1;
    step();
    ipif_rd_ack_i = '0;
    check("conc rd_ack", rd_ack_o, 1'b1);
    check("conc rd_err", rd_err_o, 1'b0);
    check("conc rd_data", rd_data_o, 32'hC0DE_0005);
    check("conc rd addr 6 untouched", ipif_rd_addr_o[6], 32'h0);
    check("conc rd addr 5 held", ipif_rd_addr_o[5], 32'h011);
    step();

    // Asynchronous reset during WAIT
    rd_addr_i = {5'd4, 10'h044}; rd_req_i = 1'b1;
    step();
    rd_req_i = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst rd_ack", rd_ack_o, 1'b0);
    check("async rst rd_data", rd_data_o, 32'h0);
    check("async rst timeout_count", timeout_count_o, 16'h0);
    check("async rst branch regs", (ipif_wr_addr_o == '0) && (ipif_wr_data_o == '0) &&
                                   (ipif_rd_addr_o == '0) && (ipif_rd_req_o == '0), 1'b1);
    step(); step();
    rst_n = 1'b1;
    step();
    ipif_rd_ack_i[4] = 1'b1;
    step();
    ipif_rd_ack_i = '0;
    check("post rst ack ignored", rd_ack_o, 1'b0);
    step();
    check("post rst ack ignored +1", rd_ack_o, 1'b0);
    do_access(mk(1'b0, 5'd4, 10'h044, 32'h0, 1, 3, 1'b0, 32'hC0DE_0004, 1, 16'd0), "post_rst");

    // Saturation: preload near the top, then two simultaneous timeouts overflow
    force dut.timeout_count_q = 16'hFFFE;
    step();
    release dut.timeout_count_q;
    step();
    check("sat preload", timeout_count_o, 16'hFFFE);
    rd_addr_i = {5'd1, 10'h000}; rd_req_i = 1'b1;
    wr_addr_i = {5'd2, 10'h000}; wr_req_i = 1'b1;
    step();
    rd_req_i = 1'b0;
    wr_req_i = 1'b0;
    lat_h = -1;
    for (int c = 1; c <= 20; c++) begin
      if (rd_ack_o || wr_ack_o) begin
        lat_h = c;
        break;
      end
      step();
    end
    check("sat dual latency", lat_h, 10);
    check("sat dual both ack", rd_ack_o && wr_ack_o, 1'b1);
    check("sat dual both err", rd_err_o && wr_err_o, 1'b1);
    check("sat dual count", timeout_count_o, 16'hFFFF);
    step();
    vh = mk(1'b0, 5'd3, 10'h000, 32'h0, -1, 10, 1'b1, 32'hDEAD_BEEF, 1, 16'hFFFF);
    do_access(vh, "sat_hold");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
